// File: rtl/fpu_div_rsp_queue_pkg.sv
// Shared FPU types for the divider response path: IEEE exception flags and small helpers.
package fpu_div_rsp_queue_pkg;

    localparam int unsigned FP_FLAGS_BITS = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic ofl;
        logic ufl;
        logic nx;
    } fflags_t;

    function automatic fflags_t gate_fflags(input logic has_fflags, input fflags_t fflags);
        return has_fflags ? fflags : fflags_t'('0);
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fpu_rsp_ram.sv
// Response storage: one synchronous write port, one asynchronous read port, no reset.
module fpu_rsp_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fpu_div_rsp_queue.sv
// FIFO between the FPU divider and the response arbiter; cleans entries on write and keeps a
// sticky fflags accumulator for the FCSR path.
module fpu_div_rsp_queue
    import fpu_div_rsp_queue_pkg::*;
#(
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned TAG_WIDTH = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [NUM_LANES-1:0]      mask_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    input  logic [NUM_LANES*32-1:0]   result_in,
    input  logic                      has_fflags_in,
    input  logic [4:0]                fflags_in,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [NUM_LANES-1:0]      mask_out,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic [NUM_LANES*32-1:0]   result_out,
    output logic                      has_fflags_out,
    output logic [4:0]                fflags_out,
    input  logic                      fflags_clr,
    output logic [4:0]                fflags_acc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [NUM_LANES-1:0]    mask;
        logic [TAG_WIDTH-1:0]    tag;
        logic [NUM_LANES*32-1:0] result;
        logic                    has_fflags;
        fflags_t                 fflags;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : gen_bad_depth
        $error("fpu_div_rsp_queue: DEPTH must be a power of two and at least 2");
    end

    logic                     push;
    logic                     pop;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     ready_q;
    logic [FP_FLAGS_BITS-1:0] acc_q, acc_d;
    entry_t                   wr_entry;
    entry_t                   rd_entry;
    logic [ENTRY_W-1:0]       rd_data;

    assign valid_out = (count_q != '0);
    assign push      = valid_in & ready_q;
    assign pop       = valid_out & ready_out;

    // Entries are stored already cleaned so the read side is a plain mux out of storage.
    always_comb begin
        wr_entry            = '0;
        wr_entry.mask       = mask_in;
        wr_entry.tag        = tag_in;
        wr_entry.has_fflags = has_fflags_in;
        wr_entry.fflags     = gate_fflags(has_fflags_in, fflags_t'(fflags_in));
        for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
            wr_entry.result[lane*32 +: 32] = mask_in[lane] ? result_in[lane*32 +: 32] : 32'h0;
        end
    end

    fpu_rsp_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign rd_entry = entry_t'(rd_data);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A clear in the same cycle as a pop keeps the popped flags.
    always_comb begin
        acc_d = (fflags_clr ? '0 : acc_q)
              | ((pop && rd_entry.has_fflags) ? rd_entry.fflags : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d < FULL_CNT);
            acc_q    <= acc_d;
        end
    end

    assign ready_in       = ready_q;
    assign count          = count_q;
    assign mask_out       = rd_entry.mask;
    assign tag_out        = rd_entry.tag;
    assign result_out     = rd_entry.result;
    assign has_fflags_out = rd_entry.has_fflags;
    assign fflags_out     = rd_entry.fflags;
    assign fflags_acc     = acc_q;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!reset) !(push && (count_q == FULL_CNT)));

    a_count_bounded: assert property (
        @(posedge clk) disable iff (!reset) (count_q <= FULL_CNT));

endmodule
